serial_source: RTL and testbench
================================

Name: serial_source

Overview:
- Traffic-injection endpoint for the NoC test fabric, and the transmit-side counterpart of the serial receiver/sink endpoint.
- Generates flits at a programmable pseudo-random injection rate and buffers them in a 4-entry FIFO.
- Serialises each flit onto a one-wire link, honouring back-pressure from the far-end receiver.
- Reports launched-flit throughput per sampling window, using the same windowing as the sink, so the two ends can be compared directly.

Parameters:
- DATA_W, 8: flit width in bits; must equal the global `ADDR_SZ`.
- RATE_W, 8: width of the rate input and of the LFSR.
- SAMPLE_BITS, 26: throughput window is 2^SAMPLE_BITS cycles.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.
- FIFO_DEPTH, 4: flit buffer depth; power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  allows flit generation.
- rate  in  RATE_W  injection threshold.
- channel_busy  in  1  high = receiver cannot accept a new frame.
- serial_out  out  1  registered serial line.
- throughput  out  SAMPLE_BITS  frames launched in the last completed window.
- dropped  out  16  saturating count of generation attempts lost to a full FIFO.

Behaviour:
- Reset: sampled at posedge only, while reset==0. On reset:
  - serial_out=0, throughput=0, dropped=0.
  - FIFO emptied, seq=0, lfsr=LFSR_SEED.
  - TX FSM returns to IDLE, sampler=0, running=0.
  - Reset mid-frame aborts the frame; the line reads 0 from the next cycle.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle out of reset regardless of enable. Its value is always in 1..255.
- Generation, per cycle:
  - fire = enable && (lfsr <= rate).
  - rate=0 never fires; rate=255 fires every enabled cycle.
- On fire:
  - If the FIFO is not full, or a pop occurs in the same cycle: push flit = seq, then seq <= seq+1 (wraps mod 2^DATA_W).
  - Otherwise: dropped <= dropped+1, saturating at 16'hFFFF; seq is unchanged.
- FIFO:
  - Simultaneous push and pop on an empty FIFO is not a bypass; the pushed flit is launched at the earliest the next cycle.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
- TX FSM, states IDLE, START, SHIFT:
  - IDLE: serial_out=0. If FIFO non-empty and channel_busy==0: pop, load shift register, go to START. channel_busy is sampled only in IDLE.
  - START: serial_out=1 (start bit). The launch counts for throughput in this cycle. Go to SHIFT with bit counter=0.
  - SHIFT: serial_out=shift[0]; data goes out LSB first. Shift right, counter increments. After DATA_W cycles return to IDLE.
- Frame timing:
  - 1 start bit + DATA_W data bits; at least 1 IDLE cycle between frames.
  - Back-to-back frame period is DATA_W+2 cycles.
  - channel_busy changes mid-frame are ignored.
- Latency: push in cycle t leads to the start bit at cycle t+2 at the earliest (registered pop into START, registered output).
- Throughput sampler, every cycle out of reset:
  - If sampler is all-ones: throughput <= running; running <= 0; sampler <= 0. A launch in this cycle is not counted.
  - Else: sampler++; running += launch.
- Turning enable off stops generation only; the FIFO keeps draining.

Decomposition:
- Shared package/defines:
  - DATA_W tied to `ADDR_SZ`.
  - Start-bit level 1'b1 and idle level 1'b0, shared with rx.
  - LFSR tap mask.
  - TX state encodings (IDLE=2'd0, START=2'd1, SHIFT=2'd2).
- Sub-module serial_tx holds the FSM and shift register. Interface: data, valid, pop, channel_busy, serial_out, launch.
- The generator, FIFO and counters stay in serial_source.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with enable=1, rate=255. Then serial_out=0, throughput=0, dropped=0, and no start bit until at least 2 cycles after reset deasserts.
- Flit sequence: rate=255, channel_busy=0. Decode frames and expect data 0,1,2,3,...; start bits exactly DATA_W+2=10 cycles apart; bits LSB first (flit 5 → 1,1,0,1,0,0,0,0,0 including the start bit).
- Back-pressure: channel_busy=1 for 100 cycles with rate=255. No start bits; FIFO fills with 4 entries and dropped reaches ≥ about 90. Release busy and expect 4 frames carrying seq 0..3, then continued generation from seq 4.
- Mid-frame busy: assert channel_busy during the SHIFT of a frame. The frame completes intact; the next start is withheld until busy falls.
- Reset mid-frame: pull reset low during bit 3 of flit 7. Line goes to 0 at the next cycle; after release the first frame carries data 0.
- Throughput: SAMPLE_BITS=4, rate=255, busy=0, run 3 windows. throughput updates at cycles 15, 31, 47 after reset. The value equals the start bits counted in each window excluding its last cycle (1–2 per 16-cycle window).

Source files
------------

// File: rtl/serial_source_pkg.sv
// Shared constants for the serial link endpoints: flit width, line levels,
// LFSR feedback taps and transmit FSM encodings.
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

package serial_source_pkg;

  localparam int FLIT_W = `ADDR_SZ;

  localparam logic START_LVL = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;

  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/serial_source_tx.sv
// One-wire frame transmitter: one start bit followed by the flit LSB first,
// with at least one idle cycle between frames.
module serial_tx
  import serial_source_pkg::*;
#(
  parameter int DATA_W = FLIT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              pop,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              launch
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         state, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              line_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= TX_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      serial_out <= IDLE_LVL;
    end else begin
      state      <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      serial_out <= line_d;
    end
  end

  // line_d is the level the line shows while in state_d
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    line_d  = IDLE_LVL;
    pop     = 1'b0;
    launch  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (valid && !channel_busy) begin
          pop     = 1'b1;
          shift_d = data;
          state_d = TX_START;
          line_d  = START_LVL;
        end
      end
      TX_START: begin
        launch  = 1'b1;
        cnt_d   = '0;
        state_d = TX_SHIFT;
        line_d  = shift_q[0];
      end
      TX_SHIFT: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = TX_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          line_d = shift_d[0];
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/serial_source.sv
// Traffic-injection endpoint: LFSR-paced flit generator, small FIFO, serial
// transmitter and a windowed launch counter matching the sink's sampler.
module serial_source
  import serial_source_pkg::*;
#(
  parameter int                DATA_W      = FLIT_W,
  parameter int                RATE_W      = 8,
  parameter int                SAMPLE_BITS = 26,
  parameter logic [RATE_W-1:0] LFSR_SEED   = 'hA5,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [RATE_W-1:0]      rate,
  input  logic                   channel_busy,
  output logic                   serial_out,
  output logic [SAMPLE_BITS-1:0] throughput,
  output logic [15:0]            dropped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [RATE_W-1:0]      lfsr;
  logic [DATA_W-1:0]      seq;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic [SAMPLE_BITS-1:0] sampler, running;
  logic                   full, empty, fire, push, pop, drop, launch;

  assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign fire  = enable && (lfsr <= rate);
  // A same-cycle pop frees a slot, so a full FIFO can still accept
  assign push  = fire && (!full || pop);
  assign drop  = fire && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= seq;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr       <= LFSR_SEED;
      seq        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dropped    <= '0;
      sampler    <= '0;
      running    <= '0;
      throughput <= '0;
    end else begin
      lfsr <= {lfsr[RATE_W-2:0], ^(lfsr & RATE_W'(LFSR_TAPS))};
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (dropped != 16'hFFFF)) dropped <= dropped + 16'd1;
      // The closing cycle of each window is never counted, as in the sink
      if (&sampler) begin
        throughput <= running;
        running    <= '0;
        sampler    <= '0;
      end else begin
        sampler <= sampler + 1'b1;
        running <= running + SAMPLE_BITS'(launch);
      end
    end
  end

  serial_tx #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk         (clk),
    .reset       (reset),
    .data        (mem[rd_ptr]),
    .valid       (!empty),
    .pop         (pop),
    .channel_busy(channel_busy),
    .serial_out  (serial_out),
    .launch      (launch)
  );

endmodule

// File: tb/tb_serial_source.sv
// Directed bench for serial_source: frame decoding, back-pressure, reset
// behaviour and windowed throughput with a short 16-cycle window.
module tb_serial_source;

  localparam int DW = 8;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    rate = '0;
  logic          channel_busy = 1'b0;
  logic          serial_out;
  logic [SB-1:0] throughput;
  logic [15:0]   dropped;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  serial_source #(
    .DATA_W     (DW),
    .RATE_W     (8),
    .SAMPLE_BITS(SB),
    .LFSR_SEED  (8'hA5),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rate        (rate),
    .channel_busy(channel_busy),
    .serial_out  (serial_out),
    .throughput  (throughput),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] rt, input logic busy);
    enable       = en;
    rate         = rt;
    channel_busy = busy;
  endtask

  // cyc counts edges after release: cyc==k means edge k-1 has passed
  task automatic applyReset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic waitStart(input string tag, input int limit, output int at);
    bit found = 0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (serial_out === 1'b1) begin
        found = 1;
        at = cyc;
        break;
      end
    end
    checkOutput({tag, "_start"}, serial_out, 1);
  endtask

  task automatic readFrame(input int busy_at, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < DW; i++) begin
      tick();
      d[i] = serial_out;
      if (i == busy_at) channel_busy = 1'b1;
    end
  endtask

  initial begin
    int at, prev, t0;
    bit seen;
    logic [7:0] d;

    // Reset with generation requested
    applyStimulus(1'b1, 8'd255, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_line", serial_out, 0);
    checkOutput("rst_throughput", throughput, 0);
    checkOutput("rst_dropped", dropped, 0);
    reset = 1'b1;
    cyc = 0;
    tick();
    checkOutput("rst_no_early_start", serial_out, 0);
    tick();
    checkOutput("first_start", serial_out, 1);

    // Flit sequence and frame period
    prev = cyc;
    readFrame(-1, d);
    checkOutput("flit0", d, 0);
    for (int n = 1; n < 6; n++) begin
      waitStart("seq", 20, at);
      checkOutput("seq_period", at - prev, 10);
      prev = at;
      readFrame(-1, d);
      checkOutput($sformatf("flit%0d", n), d, n);
    end

    // Back-pressure: FIFO holds 0..3, the remaining 96 attempts drop
    applyStimulus(1'b1, 8'd255, 1'b1);
    applyReset();
    seen = 0;
    repeat (100) begin
      tick();
      if (serial_out) seen = 1;
    end
    checkOutput("bp_no_start", seen, 0);
    checkOutput("bp_dropped", dropped, 96);
    channel_busy = 1'b0;
    for (int n = 0; n < 6; n++) begin
      waitStart("bp", 20, at);
      readFrame(-1, d);
      checkOutput($sformatf("bp_flit%0d", n), d, n);
    end

    // Busy raised mid-frame: frame completes, next start withheld
    waitStart("mid", 20, at);
    readFrame(0, d);
    checkOutput("mid_flit6", d, 6);
    seen = 0;
    repeat (20) begin
      tick();
      if (serial_out) seen = 1;
    end
    checkOutput("mid_withheld", seen, 0);
    channel_busy = 1'b0;
    t0 = cyc;
    waitStart("mid_release", 5, at);
    checkOutput("mid_release_delay", at - t0, 1);
    readFrame(-1, d);
    checkOutput("mid_flit7", d, 7);

    // Enable off: buffered flits drain, then the line stays idle
    applyStimulus(1'b1, 8'd255, 1'b1);
    applyReset();
    repeat (6) tick();
    checkOutput("drain_dropped", dropped, 2);
    applyStimulus(1'b0, 8'd255, 1'b0);
    for (int n = 0; n < 4; n++) begin
      waitStart("drain", 20, at);
      readFrame(-1, d);
      checkOutput($sformatf("drain_flit%0d", n), d, n);
    end
    seen = 0;
    repeat (30) begin
      tick();
      if (serial_out) seen = 1;
    end
    checkOutput("drain_idle", seen, 0);

    // rate 0 never fires
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyReset();
    seen = 0;
    repeat (40) begin
      tick();
      if (serial_out) seen = 1;
    end
    checkOutput("rate0_idle", seen, 0);
    checkOutput("rate0_dropped", dropped, 0);

    // Reset during bit 3 of flit 7
    applyStimulus(1'b1, 8'd255, 1'b0);
    applyReset();
    for (int n = 0; n < 7; n++) begin
      waitStart("rm", 20, at);
      readFrame(-1, d);
    end
    checkOutput("rm_flit6", d, 6);
    waitStart("rm7", 20, at);
    repeat (3) tick();
    checkOutput("rm_bit2", serial_out, 1);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rm_line_low", serial_out, 0);
    tick();
    reset = 1'b1;
    cyc = 0;
    tick();
    checkOutput("rm_no_early_start", serial_out, 0);
    tick();
    checkOutput("rm_restart", serial_out, 1);
    readFrame(-1, d);
    checkOutput("rm_flit0", d, 0);

    // Throughput over three 16-cycle windows
    applyStimulus(1'b1, 8'd255, 1'b0);
    applyReset();
    for (int j = 1; j <= 48; j++) begin
      tick();
      case (j)
        15: checkOutput("thru_pre", throughput, 0);
        16: checkOutput("thru_w0", throughput, 2);
        31: checkOutput("thru_hold", throughput, 2);
        32: checkOutput("thru_w1", throughput, 1);
        47: checkOutput("thru_hold2", throughput, 1);
        48: checkOutput("thru_w2", throughput, 2);
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
